ctrl_msg_sender: RTL and testbench

- Downstream of the game controller: captures each `ctrl_en` message (type, block coords, card, selection length, move direction) into a small FIFO.
- Packs each message into a 22-bit frame and delivers it to the interboard link over a 4-phase req/ack handshake.
- Decouples controller bursts (e.g. multi-card moves) from the slower cross-board link.
- Detects lost acknowledgements by timeout.

---
 rtl/ctrl_msg_sender.sv | 196 +++++++++++++++++++
 tb/tb_ctrl_msg_sender.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/ctrl_msg_sender.sv
// Queues game-control messages and ships each one as a 22-bit frame over a
// 4-phase req/ack link, with overflow and ack-timeout detection.
module ctrl_msg_sender #(
    parameter int FIFO_DEPTH  = 4,
    parameter int ACK_TIMEOUT = 1000000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        transmit,
    input  logic        ctrl_en,
    input  logic        ctrl_move_dir,
    input  logic [4:0]  ctrl_block_x,
    input  logic [2:0]  ctrl_block_y,
    input  logic [3:0]  ctrl_msg_type,
    input  logic [5:0]  ctrl_card,
    input  logic [2:0]  ctrl_sel_len,
    input  logic        link_ack,
    output logic        link_req,
    output logic [21:0] link_data,
    output logic        busy,
    output logic        fifo_full,
    output logic        overflow,
    output logic        link_error,
    output logic        sent_pulse
);

    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int TW = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT + 1) : 1;
    localparam logic [AW:0]   FULL_CNT = (AW + 1)'(FIFO_DEPTH);
    localparam logic [TW-1:0] TMO_LAST = TW'(ACK_TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_REL  = 2'd2
    } state_t;

    state_t        r_state;
    state_t        w_state_nxt;
    logic [21:0]   r_mem [FIFO_DEPTH];
    logic [AW-1:0] r_wptr;
    logic [AW-1:0] r_rptr;
    logic [AW:0]   r_count;
    logic [TW-1:0] r_tmo;
    logic [TW-1:0] w_tmo_nxt;
    logic          r_ack_meta;
    logic          r_ack_s;
    logic          r_link_req;
    logic [21:0]   r_link_data;
    logic          r_overflow;
    logic          r_link_error;
    logic          r_sent;
    logic          w_req_nxt;
    logic          w_load;
    logic          w_pop;
    logic          w_sent_nxt;
    logic          w_err_set;
    logic          w_full;
    logic          w_empty;
    logic          w_wr_req;
    logic          w_push;
    logic          w_drop;
    logic [21:0]   w_frame;

    assign w_frame = {ctrl_msg_type, ctrl_block_x, ctrl_block_y,
                      ctrl_card, ctrl_sel_len, ctrl_move_dir};

    assign w_full   = (r_count == FULL_CNT);
    assign w_empty  = (r_count == '0);
    assign w_wr_req = ctrl_en & transmit;
    // A pop in the same cycle frees a slot, so a push into a full FIFO still lands.
    assign w_push   = w_wr_req & (~w_full | w_pop);
    assign w_drop   = w_wr_req & w_full & ~w_pop;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wptr] <= w_frame;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + AW'(1);
            end
            if (w_pop) begin
                r_rptr <= r_rptr + AW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + (AW + 1)'(1);
                2'b01:   r_count <= r_count - (AW + 1)'(1);
                default: r_count <= r_count;
            endcase
            if (w_drop) begin
                r_overflow <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ack_meta <= 1'b0;
            r_ack_s    <= 1'b0;
        end else begin
            r_ack_meta <= link_ack;
            r_ack_s    <= r_ack_meta;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_tmo        <= '0;
            r_link_req   <= 1'b0;
            r_link_data  <= '0;
            r_sent       <= 1'b0;
            r_link_error <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_tmo      <= w_tmo_nxt;
            r_link_req <= w_req_nxt;
            r_sent     <= w_sent_nxt;
            if (w_load) begin
                r_link_data <= r_mem[r_rptr];
            end
            if (w_err_set) begin
                r_link_error <= 1'b1;
            end
        end
    end

    // The head entry stays queued until the release phase ends, so a request
    // timeout simply re-sends it from IDLE.
    always_comb begin
        w_state_nxt = r_state;
        w_tmo_nxt   = '0;
        w_req_nxt   = r_link_req;
        w_load      = 1'b0;
        w_pop       = 1'b0;
        w_sent_nxt  = 1'b0;
        w_err_set   = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_req_nxt = 1'b0;
                if (!w_empty && !r_ack_s) begin
                    w_load      = 1'b1;
                    w_req_nxt   = 1'b1;
                    w_state_nxt = S_REQ;
                end
            end
            S_REQ: begin
                if (r_ack_s) begin
                    w_req_nxt   = 1'b0;
                    w_state_nxt = S_REL;
                end else if (r_tmo == TMO_LAST) begin
                    w_err_set   = 1'b1;
                    w_req_nxt   = 1'b0;
                    w_state_nxt = S_IDLE;
                end else begin
                    w_tmo_nxt = r_tmo + TW'(1);
                end
            end
            S_REL: begin
                if (!r_ack_s) begin
                    w_pop       = 1'b1;
                    w_sent_nxt  = 1'b1;
                    w_state_nxt = S_IDLE;
                end else if (r_tmo == TMO_LAST) begin
                    w_err_set   = 1'b1;
                    w_pop       = 1'b1;
                    w_state_nxt = S_IDLE;
                end else begin
                    w_tmo_nxt = r_tmo + TW'(1);
                end
            end
            default: begin
                w_req_nxt   = 1'b0;
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    assign link_req   = r_link_req;
    assign link_data  = r_link_data;
    assign busy       = (r_state != S_IDLE) | ~w_empty;
    assign fifo_full  = w_full;
    assign overflow   = r_overflow;
    assign link_error = r_link_error;
    assign sent_pulse = r_sent;

endmodule

// File: tb/tb_ctrl_msg_sender.sv
// Directed bench for ctrl_msg_sender: latency, burst/overflow, gating,
// ack timeout with retry, async reset mid-request and push/pop at full.
module tb_ctrl_msg_sender;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        transmit = 1'b0;
    logic        ctrl_en = 1'b0;
    logic        ctrl_move_dir = 1'b0;
    logic [4:0]  ctrl_block_x = '0;
    logic [2:0]  ctrl_block_y = '0;
    logic [3:0]  ctrl_msg_type = '0;
    logic [5:0]  ctrl_card = '0;
    logic [2:0]  ctrl_sel_len = '0;
    logic        link_ack = 1'b0;
    logic        link_req;
    logic [21:0] link_data;
    logic        busy;
    logic        fifo_full;
    logic        overflow;
    logic        link_error;
    logic        sent_pulse;

    int errorCount = 0;
    int checkCount = 0;
    int sentCount  = 0;

    ctrl_msg_sender #(.FIFO_DEPTH(4), .ACK_TIMEOUT(16)) dut (
        .clk(clk), .rst(rst), .transmit(transmit), .ctrl_en(ctrl_en),
        .ctrl_move_dir(ctrl_move_dir), .ctrl_block_x(ctrl_block_x),
        .ctrl_block_y(ctrl_block_y), .ctrl_msg_type(ctrl_msg_type),
        .ctrl_card(ctrl_card), .ctrl_sel_len(ctrl_sel_len),
        .link_ack(link_ack), .link_req(link_req), .link_data(link_data),
        .busy(busy), .fifo_full(fifo_full), .overflow(overflow),
        .link_error(link_error), .sent_pulse(sent_pulse)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (!rst && sent_pulse) sentCount++;
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [21:0] packFrame(input logic [3:0] t, input logic [4:0] x,
                                              input logic [2:0] y, input logic [5:0] c,
                                              input logic [2:0] s, input logic d);
        return {t, x, y, c, s, d};
    endfunction

    task automatic applyStimulus(input logic [3:0] t, input logic [4:0] x,
                                 input logic [2:0] y, input logic [5:0] c,
                                 input logic [2:0] s, input logic d);
        ctrl_msg_type = t;
        ctrl_block_x  = x;
        ctrl_block_y  = y;
        ctrl_card     = c;
        ctrl_sel_len  = s;
        ctrl_move_dir = d;
        ctrl_en       = 1'b1;
        tick();
        ctrl_en       = 1'b0;
    endtask

    task automatic resetDut();
        ctrl_en  = 1'b0;
        link_ack = 1'b0;
        rst      = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        tick();
    endtask

    // Waits for a fresh low-to-high transition of link_req.
    task automatic waitReqRise(input string tag);
        int n = 0;
        logic prev = link_req;
        while (!(link_req && !prev) && n < 100) begin
            prev = link_req;
            tick();
            n++;
        end
        if (!(link_req && !prev)) checkOutput({tag, "_req_timeout"}, 0, 1);
    endtask

    task automatic doHandshake(input string tag, input logic [21:0] expData);
        int n;
        waitReqRise(tag);
        checkOutput({tag, "_data"}, 32'(link_data), 32'(expData));
        link_ack = 1'b1;
        n = 0;
        while (link_req && n < 20) begin tick(); n++; end
        checkOutput({tag, "_req_fall"}, 32'(link_req), 0);
        link_ack = 1'b0;
        n = 0;
        while (!sent_pulse && n < 20) begin tick(); n++; end
        checkOutput({tag, "_sent"}, 32'(sent_pulse), 1);
    endtask

    logic [21:0] burstFrames [5];

    initial begin
        int n;
        logic [21:0] frame;

        // Reset state
        tick();
        checkOutput("rst_req", 32'(link_req), 0);
        checkOutput("rst_data", 32'(link_data), 0);
        checkOutput("rst_busy", 32'(busy), 0);
        checkOutput("rst_full", 32'(fifo_full), 0);
        checkOutput("rst_ovf", 32'(overflow), 0);
        checkOutput("rst_err", 32'(link_error), 0);
        checkOutput("rst_sent", 32'(sent_pulse), 0);
        rst = 1'b0;
        tick();

        // Single message with latency measurements
        transmit = 1'b1;
        applyStimulus(4'd5, 5'd3, 3'd2, 6'd17, 3'd1, 1'b0);
        n = 1;
        while (!link_req && n < 20) begin tick(); n++; end
        checkOutput("single_req_latency", n, 2);
        checkOutput("single_data", 32'(link_data), 32'h146912);
        link_ack = 1'b1;
        n = 0;
        while (link_req && n < 20) begin tick(); n++; end
        // two synchronizer stages plus the registered decision
        checkOutput("single_ack_to_req_fall", n, 3);
        link_ack = 1'b0;
        n = 0;
        while (!sent_pulse && n < 20) begin tick(); n++; end
        checkOutput("single_ackfall_to_sent", n, 3);
        tick();
        checkOutput("single_sent_one_cycle", 32'(sent_pulse), 0);
        checkOutput("single_busy_after", 32'(busy), 0);
        checkOutput("single_data_held", 32'(link_data), 32'h146912);
        checkOutput("single_no_err", 32'(link_error), 0);

        // Gating with transmit low
        resetDut();
        transmit = 1'b0;
        applyStimulus(4'd9, 5'd1, 3'd1, 6'd1, 3'd1, 1'b1);
        tick();
        checkOutput("gate_busy", 32'(busy), 0);
        checkOutput("gate_ovf", 32'(overflow), 0);
        checkOutput("gate_req", 32'(link_req), 0);

        // Burst of five into a four-deep FIFO
        resetDut();
        transmit = 1'b1;
        for (int i = 0; i < 5; i++) begin
            burstFrames[i] = packFrame(4'(i + 1), 5'(7 * i + 2), 3'(i), 6'(11 * i + 3), 3'(i + 2), 1'(i));
            applyStimulus(4'(i + 1), 5'(7 * i + 2), 3'(i), 6'(11 * i + 3), 3'(i + 2), 1'(i));
        end
        checkOutput("burst_full", 32'(fifo_full), 1);
        checkOutput("burst_ovf", 32'(overflow), 1);
        checkOutput("burst_busy", 32'(busy), 1);
        transmit = 1'b0;
        sentCount = 0;
        for (int i = 0; i < 4; i++) begin
            doHandshake($sformatf("burst%0d", i), burstFrames[i]);
        end
        tick();
        checkOutput("burst_sent_count", sentCount, 4);
        checkOutput("burst_drained", 32'(busy), 0);
        checkOutput("burst_not_full", 32'(fifo_full), 0);

        // Ack timeout and retry, then async reset mid-request
        resetDut();
        transmit = 1'b1;
        frame = packFrame(4'd12, 5'd30, 3'd7, 6'd42, 3'd6, 1'b1);
        applyStimulus(4'd12, 5'd30, 3'd7, 6'd42, 3'd6, 1'b1);
        waitReqRise("tmo");
        n = 0;
        while (link_req && n < 40) begin tick(); n++; end
        checkOutput("tmo_req_cycles", n, 16);
        checkOutput("tmo_err", 32'(link_error), 1);
        tick();
        checkOutput("tmo_retry_req", 32'(link_req), 1);
        checkOutput("tmo_retry_data", 32'(link_data), 32'(frame));
        #2;
        rst = 1'b1;
        #1;
        checkOutput("arst_req", 32'(link_req), 0);
        checkOutput("arst_data", 32'(link_data), 0);
        checkOutput("arst_busy", 32'(busy), 0);
        checkOutput("arst_err", 32'(link_error), 0);
        tick();
        rst = 1'b0;
        tick();
        tick();
        checkOutput("arst_fifo_empty", 32'(link_req), 0);

        // Push coinciding with a pop while full
        resetDut();
        transmit = 1'b1;
        for (int i = 0; i < 4; i++) begin
            applyStimulus(4'(i), 5'(i), 3'(i), 6'(i), 3'(i), 1'b0);
        end
        checkOutput("pp_full_before", 32'(fifo_full), 1);
        link_ack = 1'b1;
        n = 0;
        while (link_req && n < 20) begin tick(); n++; end
        link_ack = 1'b0;
        tick();
        tick();
        applyStimulus(4'd15, 5'd31, 3'd5, 6'd63, 3'd7, 1'b1);
        checkOutput("pp_sent", 32'(sent_pulse), 1);
        checkOutput("pp_still_full", 32'(fifo_full), 1);
        checkOutput("pp_no_ovf", 32'(overflow), 0);

        $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
        $finish;
    end

endmodule
